// File: rtl/risc_v_pipeline_pkg.sv
// rtl/risc_v_pipeline_pkg.sv - shared types and constants for the fetch front end
package risc_v_pipeline_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        FE_IDLE = 1'b0,
        FE_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic            pend;
        logic            fill;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// rtl/inst_fetch_unit_fetch_buffer.sv - in-order fetch buffer: allocate on grant, fill on response, pop at head
module fetch_buffer
    import risc_v_pipeline_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int PW = $clog2(BUF_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic            head_valid_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_inst_o,
    output logic [CW-1:0]   occupancy_o,
    output logic [CW-1:0]   pend_cnt_o
);

    fetch_entry_t  entry_q [BUF_DEPTH];
    fetch_entry_t  entry_d [BUF_DEPTH];
    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PW-1:0] head_ptr_q, head_ptr_d;
    logic          do_pop;

    assign head_valid_o = entry_q[head_ptr_q].fill;
    assign head_pc_o    = entry_q[head_ptr_q].pc;
    assign head_inst_o  = entry_q[head_ptr_q].inst;
    assign do_pop       = pop_i && head_valid_o;

    // Counts come straight from the entry flags so they can never drift from the array.
    always_comb begin
        occupancy_o = '0;
        pend_cnt_o  = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            occupancy_o = occupancy_o + CW'(entry_q[i].pend | entry_q[i].fill);
            pend_cnt_o  = pend_cnt_o + CW'(entry_q[i].pend);
        end
    end

    always_comb begin
        entry_d     = entry_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        if (flush_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_d[i].pend = 1'b0;
                entry_d[i].fill = 1'b0;
            end
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
        end else begin
            // Alloc, fill and pop always touch three distinct slots, so their order here is free.
            if (alloc_i) begin
                entry_d[alloc_ptr_q].pend = 1'b1;
                entry_d[alloc_ptr_q].fill = 1'b0;
                entry_d[alloc_ptr_q].pc   = alloc_pc_i;
                alloc_ptr_d               = alloc_ptr_q + PW'(1);
            end
            if (fill_i) begin
                entry_d[fill_ptr_q].pend = 1'b0;
                entry_d[fill_ptr_q].fill = 1'b1;
                entry_d[fill_ptr_q].inst = fill_data_i;
                fill_ptr_d               = fill_ptr_q + PW'(1);
            end
            if (do_pop) begin
                entry_d[head_ptr_q].fill = 1'b0;
                head_ptr_d               = head_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_q[i].pend <= 1'b0;
                entry_q[i].fill <= 1'b0;
                entry_q[i].pc   <= '0;
                entry_q[i].inst <= INST_NOP;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC, imem request/response handshake, redirect flush and decode-side handshake
module inst_fetch_unit
    import risc_v_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] occupancy, pend_cnt;
    logic [SW-1:0] credit_used;
    logic          grant, fill, pop, head_valid;
    logic [31:0]   head_pc, head_inst;

    // Words still owed to the flushed path hold credit, so imem never sees more than BUF_DEPTH outstanding.
    assign credit_used = SW'(occupancy) + SW'(drop_cnt_q);
    assign imem_req_o  = (state_q == FE_RUN) && (credit_used < SW'(BUF_DEPTH)) && !redirect_i;
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;
    assign fill        = imem_rvalid_i && !redirect_i && (drop_cnt_q == '0) && (pend_cnt != '0);
    assign pop         = inst_ready_i && !redirect_i;

    always_comb begin
        state_d    = fetch_en_i ? FE_RUN : FE_IDLE;
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_i) begin
            pc_d       = redirect_pc_i & ~32'h3;
            drop_cnt_d = drop_cnt_q + pend_cnt + CW'(grant);
            if (imem_rvalid_i && (drop_cnt_d != '0)) begin
                drop_cnt_d = drop_cnt_d - CW'(1);
            end
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rvalid_i && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FE_IDLE;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_i),
        .alloc_i      (grant),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_data_i  (imem_rdata_i),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_inst_o  (head_inst),
        .occupancy_o  (occupancy),
        .pend_cnt_o   (pend_cnt)
    );

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head_inst : INST_NOP;
    assign pc_o         = head_valid ? head_pc : 32'h0;
    assign pc_plus4_o   = pc_o + 32'd4;

    // A response with nothing pending and nothing to drop breaks the in-order imem contract.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid_i |-> (redirect_i || (drop_cnt_q != '0) || (pend_cnt != '0)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench with an in-order imem model and instruction-stream reference
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o, pc_o, pc_plus4_o;

    inst_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] p4; int cyc; } pop_t;
    typedef struct { logic [31:0] addr; int cyc; } gnt_t;
    typedef struct { int cyc; logic [31:0] target; } redir_t;

    req_t   imq[$];
    pop_t   pops[$];
    gnt_t   gnts[$];
    redir_t redirs[$];
    int     cyc, gnt_pct, lat_min, lat_max, max_out, req_cnt;
    bit     fe_want, last_valid, last_rvalid, last_req;
    int     checks, passes;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
        req_t r;
        pop_t p;
        gnt_t g;
        int   lat;
        @(negedge clk);
        fetch_en_i    = fe_want;
        inst_ready_i  = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        if (imq.size() > 0 && imq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(imq[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        last_valid  = inst_valid_o;
        last_rvalid = imem_rvalid_i;
        last_req    = imem_req_o;
        if (imem_req_o) req_cnt++;
        if (inst_valid_o && rdy && !redir) begin
            p.pc = pc_o; p.inst = inst_o; p.p4 = pc_plus4_o; p.cyc = cyc;
            pops.push_back(p);
        end
        if (imem_rvalid_i) void'(imq.pop_front());
        if (imem_req_o && imem_gnt_i) begin
            lat = $urandom_range(lat_max, lat_min);
            r.addr = imem_addr_o; r.due = cyc + lat;
            imq.push_back(r);
            g.addr = imem_addr_o; g.cyc = cyc;
            gnts.push_back(g);
        end
        if (imq.size() > max_out) max_out = imq.size();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fe_want = 1'b0; fetch_en_i = 1'b0; redirect_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
        imq.delete(); pops.delete(); gnts.delete(); redirs.delete();
        max_out = 0; req_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req_o); else passes++;
        checks++; if (imem_addr_o !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr_o, RESET_PC); else passes++;
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", inst_valid_o); else passes++;
        checks++; if (inst_o !== 32'h0000_0013) $display("FAIL reset_inst: got %h want 00000013", inst_o); else passes++;
        checks++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc_o); else passes++;
        checks++; if (pc_plus4_o !== 32'h4) $display("FAIL reset_pc4: got %h want 4", pc_plus4_o); else passes++;
        rst_n = 1'b1;
        gnt_pct = 100; lat_min = 1; lat_max = 1; fe_want = 1'b0;
        repeat (4) cycle(1'b1, 1'b0, '0);
        checks++; if (req_cnt !== 0) $display("FAIL idle_no_req: got %0d reqs want 0", req_cnt); else passes++;
    endtask

    task automatic test_sequential();
        int start;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; fe_want = 1'b1;
        start = cyc;
        repeat (24) cycle(1'b1, 1'b0, '0);
        checks++; if (pops.size() < 8) $display("FAIL seq_count: got %0d pops want >=8", pops.size()); else passes++;
        if (pops.size() > 0) begin
            checks++; if (pops[0].cyc !== start + 3) $display("FAIL seq_latency: first valid cycle %0d want %0d", pops[0].cyc - start, 3); else passes++;
        end
        if (gnts.size() > 0) begin
            checks++; if (gnts[0].cyc !== start + 1) $display("FAIL seq_first_req: cycle %0d want 1", gnts[0].cyc - start); else passes++;
        end
        for (int i = 0; i < gnts.size(); i++) begin
            checks++; if (gnts[i].addr !== RESET_PC + 32'(4 * i)) $display("FAIL seq_addr[%0d]: got %h want %h", i, gnts[i].addr, RESET_PC + 32'(4 * i)); else passes++;
        end
        for (int i = 0; i < pops.size(); i++) begin
            checks++; if (pops[i].pc !== RESET_PC + 32'(4 * i)) $display("FAIL seq_pc[%0d]: got %h want %h", i, pops[i].pc, RESET_PC + 32'(4 * i)); else passes++;
            checks++; if (pops[i].inst !== mem_word(RESET_PC + 32'(4 * i))) $display("FAIL seq_inst[%0d]: got %h want %h", i, pops[i].inst, mem_word(RESET_PC + 32'(4 * i))); else passes++;
            checks++; if (pops[i].p4 !== RESET_PC + 32'(4 * i + 4)) $display("FAIL seq_pc4[%0d]: got %h want %h", i, pops[i].p4, RESET_PC + 32'(4 * i + 4)); else passes++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; fe_want = 1'b1;
        repeat (12) cycle(1'b0, 1'b0, '0);
        checks++; if (gnts.size() !== BUF_DEPTH) $display("FAIL stall_grants: got %0d want %0d", gnts.size(), BUF_DEPTH); else passes++;
        checks++; if (last_req !== 1'b0) $display("FAIL stall_req_low: got %0b want 0", last_req); else passes++;
        checks++; if (last_valid !== 1'b1) $display("FAIL stall_head_valid: got %0b want 1", last_valid); else passes++;
        repeat (20) cycle(1'b1, 1'b0, '0);
        checks++; if (pops.size() < 6) $display("FAIL stall_drain_count: got %0d want >=6", pops.size()); else passes++;
        for (int i = 0; i < pops.size(); i++) begin
            checks++; if (pops[i].pc !== RESET_PC + 32'(4 * i)) $display("FAIL stall_order[%0d]: got %h want %h", i, pops[i].pc, RESET_PC + 32'(4 * i)); else passes++;
        end
        checks++; if (max_out > BUF_DEPTH) $display("FAIL stall_outstanding: got %0d want <=%0d", max_out, BUF_DEPTH); else passes++;
    endtask

    task automatic test_redirect();
        int ng, np;
        bit found;
        do_reset();
        gnt_pct = 100; lat_min = 3; lat_max = 3; fe_want = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imq.size() == 2 && imq[0].due > cyc) found = 1'b1;
            else cycle(1'b1, 1'b0, '0);
        end
        checks++; if (!found) $display("FAIL redir_setup: got no 2-pending window want one within 20 cycles"); else passes++;
        ng = gnts.size(); np = pops.size();
        cycle(1'b1, 1'b1, 32'h0000_0103);
        repeat (30) cycle(1'b1, 1'b0, '0);
        checks++; if (gnts.size() <= ng || gnts[ng].addr !== 32'h100) $display("FAIL redir_addr: got %h want 00000100", (gnts.size() > ng) ? gnts[ng].addr : 32'hx); else passes++;
        checks++; if (pops.size() < np + 3) $display("FAIL redir_count: got %0d pops want >=%0d", pops.size(), np + 3); else passes++;
        for (int i = np; i < pops.size(); i++) begin
            checks++; if (pops[i].pc !== 32'h100 + 32'(4 * (i - np))) $display("FAIL redir_pc[%0d]: got %h want %h", i, pops[i].pc, 32'h100 + 32'(4 * (i - np))); else passes++;
            checks++; if (pops[i].inst !== mem_word(pops[i].pc)) $display("FAIL redir_inst[%0d]: got %h want %h", i, pops[i].inst, mem_word(pops[i].pc)); else passes++;
            checks++; if (pops[i].p4 !== 32'h104 + 32'(4 * (i - np))) $display("FAIL redir_pc4[%0d]: got %h want %h", i, pops[i].p4, 32'h104 + 32'(4 * (i - np))); else passes++;
        end
        checks++; if (max_out > BUF_DEPTH) $display("FAIL redir_outstanding: got %0d want <=%0d", max_out, BUF_DEPTH); else passes++;
    endtask

    task automatic test_redirect_collide();
        int ng;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; fe_want = 1'b1;
        repeat (3) cycle(1'b1, 1'b0, '0);
        ng = gnts.size();
        cycle(1'b1, 1'b1, 32'h0000_0200);
        checks++; if (last_valid !== 1'b1 || last_rvalid !== 1'b1) $display("FAIL coll_setup: got valid=%0b rvalid=%0b want 1 1", last_valid, last_rvalid); else passes++;
        cycle(1'b1, 1'b0, '0);
        checks++; if (last_valid !== 1'b0) $display("FAIL coll_valid_after: got %0b want 0", last_valid); else passes++;
        checks++; if (last_req !== 1'b1) $display("FAIL coll_req_next: got %0b want 1", last_req); else passes++;
        repeat (20) cycle(1'b1, 1'b0, '0);
        checks++; if (gnts.size() <= ng || gnts[ng].addr !== 32'h200) $display("FAIL coll_addr: got %h want 00000200", (gnts.size() > ng) ? gnts[ng].addr : 32'hx); else passes++;
        checks++; if (pops.size() < 5) $display("FAIL coll_count: got %0d want >=5", pops.size()); else passes++;
        for (int i = 0; i < pops.size(); i++) begin
            checks++; if (pops[i].pc !== 32'h200 + 32'(4 * i)) $display("FAIL coll_pc[%0d]: got %h want %h", i, pops[i].pc, 32'h200 + 32'(4 * i)); else passes++;
            checks++; if (pops[i].inst !== mem_word(32'h200 + 32'(4 * i))) $display("FAIL coll_inst[%0d]: got %h want %h", i, pops[i].inst, mem_word(32'h200 + 32'(4 * i))); else passes++;
        end
    endtask

    task automatic test_fetch_enable();
        int          ng, np;
        logic [31:0] last_addr;
        do_reset();
        gnt_pct = 100; lat_min = 2; lat_max = 2; fe_want = 1'b1;
        repeat (15) cycle(1'b1, 1'b0, '0);
        fe_want = 1'b0;
        cycle(1'b1, 1'b0, '0);
        ng = gnts.size(); req_cnt = 0;
        repeat (12) cycle(1'b1, 1'b0, '0);
        np = pops.size();
        checks++; if (req_cnt !== 0) $display("FAIL fen_no_req: got %0d reqs want 0", req_cnt); else passes++;
        checks++; if (last_valid !== 1'b0 || imq.size() !== 0) $display("FAIL fen_drained: got valid=%0b outstanding=%0d want 0 0", last_valid, imq.size()); else passes++;
        checks++; if (np !== ng) $display("FAIL fen_none_lost: got %0d pops want %0d", np, ng); else passes++;
        last_addr = (ng > 0) ? gnts[ng - 1].addr : 32'hx;
        fe_want = 1'b1;
        repeat (12) cycle(1'b1, 1'b0, '0);
        checks++; if (gnts.size() <= ng || gnts[ng].addr !== last_addr + 32'd4) $display("FAIL fen_resume: got %h want %h", (gnts.size() > ng) ? gnts[ng].addr : 32'hx, last_addr + 32'd4); else passes++;
        for (int i = 0; i < pops.size(); i++) begin
            checks++; if (pops[i].pc !== RESET_PC + 32'(4 * i)) $display("FAIL fen_order[%0d]: got %h want %h", i, pops[i].pc, RESET_PC + 32'(4 * i)); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; fe_want = 1'b1;
        repeat (8) cycle(1'b0, 1'b0, '0);
        checks++; if (last_valid !== 1'b1) $display("FAIL rstmid_full: got valid=%0b want 1", last_valid); else passes++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0) $display("FAIL rstmid_req: got %0b want 0", imem_req_o); else passes++;
        checks++; if (imem_addr_o !== RESET_PC) $display("FAIL rstmid_addr: got %h want %h", imem_addr_o, RESET_PC); else passes++;
        checks++; if (inst_valid_o !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", inst_valid_o); else passes++;
        checks++; if (inst_o !== 32'h0000_0013) $display("FAIL rstmid_inst: got %h want 00000013", inst_o); else passes++;
        checks++; if (pc_o !== 32'h0 || pc_plus4_o !== 32'h4) $display("FAIL rstmid_pc: got %h/%h want 0/4", pc_o, pc_plus4_o); else passes++;
        imq.delete(); pops.delete(); gnts.delete(); max_out = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cycle(1'b1, 1'b0, '0);
        checks++; if (gnts.size() == 0 || gnts[0].addr !== RESET_PC) $display("FAIL rstmid_restart_addr: got %h want %h", (gnts.size() > 0) ? gnts[0].addr : 32'hx, RESET_PC); else passes++;
        checks++; if (pops.size() == 0 || pops[0].pc !== RESET_PC) $display("FAIL rstmid_restart_pc: got %h want %h", (pops.size() > 0) ? pops[0].pc : 32'hx, RESET_PC); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        redir_t      rd;
        int          ri;
        bit          rdy, redir;
        do_reset();
        gnt_pct = 60; lat_min = 1; lat_max = 4; fe_want = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rdy   = ($urandom_range(99) < 70);
            redir = ($urandom_range(99) < 4);
            rd.cyc = cyc; rd.target = $urandom;
            if (redir) redirs.push_back(rd);
            cycle(rdy, redir, rd.target);
        end
        repeat (10) cycle(1'b1, 1'b0, '0);
        checks++; if (pops.size() < 20) $display("FAIL rand_count: got %0d pops want >=20", pops.size()); else passes++;
        checks++; if (max_out > BUF_DEPTH) $display("FAIL rand_outstanding: got %0d want <=%0d", max_out, BUF_DEPTH); else passes++;
        exp_pc = RESET_PC; ri = 0;
        for (int i = 0; i < pops.size(); i++) begin
            while (ri < redirs.size() && redirs[ri].cyc < pops[i].cyc) begin
                exp_pc = redirs[ri].target & ~32'h3;
                ri++;
            end
            checks++; if (pops[i].pc !== exp_pc) $display("FAIL rand_pc[%0d]: got %h want %h", i, pops[i].pc, exp_pc); else passes++;
            checks++; if (pops[i].inst !== mem_word(exp_pc)) $display("FAIL rand_inst[%0d]: got %h want %h", i, pops[i].inst, mem_word(exp_pc)); else passes++;
            checks++; if (pops[i].p4 !== exp_pc + 32'd4) $display("FAIL rand_pc4[%0d]: got %h want %h", i, pops[i].p4, exp_pc + 32'd4); else passes++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        checks = 0; passes = 0; cyc = 0; max_out = 0; req_cnt = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; fe_want = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_fetch_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
